// File: rtl/axi_adapter_arbiter.sv
// rtl/axi_adapter_arbiter.sv - single-outstanding arbiter from cache requesters onto the AXI adapter
// Define ARB_ROUND_ROBIN_EN for round-robin arbitration; default build is fixed priority (lowest index wins).
module axi_adapter_arbiter #(
  parameter int unsigned NR_PORTS       = 3,
  parameter int unsigned DATA_WIDTH     = 256,
  parameter int unsigned AXI_DATA_WIDTH = 64,
  parameter int unsigned AXI_ID_WIDTH   = 4,
  parameter int unsigned ADDR_WIDTH     = 64
) (
  input  logic                                   clk_i,
  input  logic                                   rst_ni,
  input  logic [NR_PORTS-1:0]                    req_i,
  input  logic [NR_PORTS-1:0]                    burst_i,
  input  logic [NR_PORTS-1:0]                    we_i,
  input  logic [NR_PORTS-1:0][ADDR_WIDTH-1:0]    addr_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH-1:0]    wdata_i,
  input  logic [NR_PORTS-1:0][DATA_WIDTH/8-1:0]  be_i,
  input  logic [NR_PORTS-1:0][1:0]               size_i,
  output logic [NR_PORTS-1:0]                    gnt_o,
  output logic [NR_PORTS-1:0]                    valid_o,
  output logic [DATA_WIDTH-1:0]                  rdata_o,
  output logic                                   adp_req_o,
  output logic                                   adp_burst_o,
  output logic                                   adp_we_o,
  output logic [ADDR_WIDTH-1:0]                  adp_addr_o,
  output logic [DATA_WIDTH-1:0]                  adp_wdata_o,
  output logic [DATA_WIDTH/8-1:0]                adp_be_o,
  output logic [1:0]                             adp_size_o,
  output logic [AXI_ID_WIDTH-1:0]                adp_id_o,
  input  logic                                   adp_gnt_i,
  input  logic                                   adp_valid_i,
  input  logic [DATA_WIDTH-1:0]                  adp_rdata_i,
  input  logic [AXI_ID_WIDTH-1:0]                adp_id_i,
  output logic                                   error_o
);

  localparam int unsigned IDX_W = (NR_PORTS > 1) ? $clog2(NR_PORTS) : 1;
  localparam int unsigned BE_W  = DATA_WIDTH / 8;

  if ((NR_PORTS < 1) || (NR_PORTS > 16) || (NR_PORTS > (1 << AXI_ID_WIDTH)) ||
      ((DATA_WIDTH % AXI_DATA_WIDTH) != 0)) begin : g_bad_params
    $fatal(1, "axi_adapter_arbiter: illegal parameter combination");
  end

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT_RSP} state_e;

  state_e                state_q, state_d;
  logic [IDX_W-1:0]      idx_q, idx_d;
  logic                  burst_q, burst_d;
  logic                  we_q, we_d;
  logic [ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0] wdata_q, wdata_d;
  logic [BE_W-1:0]       be_q, be_d;
  logic [1:0]            size_q, size_d;
  logic                  error_q, error_d;

  logic [IDX_W-1:0]      win_idx;
  logic                  capture;
  logic                  rsp_hit;

  assign capture = (state_q == IDLE) && (|req_i);
  assign rsp_hit = adp_valid_i && (state_q == WAIT_RSP) && (adp_id_i == AXI_ID_WIDTH'(idx_q));

`ifdef ARB_ROUND_ROBIN_EN
  logic [IDX_W-1:0] rr_ptr_q, rr_ptr_d;
  logic [IDX_W-1:0] rr_cand;

  // Walk from farthest to nearest so the closest requester after the pointer wins.
  always_comb begin
    win_idx = '0;
    rr_cand = '0;
    for (int i = int'(NR_PORTS); i >= 1; i--) begin
      rr_cand = IDX_W'((int'(rr_ptr_q) + i) % int'(NR_PORTS));
      if (req_i[rr_cand]) win_idx = rr_cand;
    end
  end

  always_comb begin
    rr_ptr_d = rr_ptr_q;
    if (capture) rr_ptr_d = win_idx;
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) rr_ptr_q <= IDX_W'(NR_PORTS - 1);
    else         rr_ptr_q <= rr_ptr_d;
  end
`else
  always_comb begin
    win_idx = '0;
    for (int i = int'(NR_PORTS) - 1; i >= 0; i--) begin
      if (req_i[i]) win_idx = IDX_W'(i);
    end
  end
`endif

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q <= IDLE;
      idx_q   <= '0;
      burst_q <= 1'b0;
      we_q    <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      be_q    <= '0;
      size_q  <= '0;
      error_q <= 1'b0;
    end else begin
      state_q <= state_d;
      idx_q   <= idx_d;
      burst_q <= burst_d;
      we_q    <= we_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      be_q    <= be_d;
      size_q  <= size_d;
      error_q <= error_d;
    end
  end

  always_comb begin
    state_d = state_q;
    idx_d   = idx_q;
    burst_d = burst_q;
    we_d    = we_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    be_d    = be_q;
    size_d  = size_q;
    // Any response that does not complete the outstanding transaction is dropped and flagged.
    error_d = error_q | (adp_valid_i & ~rsp_hit);
    unique case (state_q)
      IDLE: begin
        if (capture) begin
          state_d = ISSUE;
          idx_d   = win_idx;
          burst_d = burst_i[win_idx];
          we_d    = we_i[win_idx];
          addr_d  = addr_i[win_idx];
          wdata_d = wdata_i[win_idx];
          be_d    = be_i[win_idx];
          size_d  = size_i[win_idx];
        end
      end
      ISSUE:    if (adp_gnt_i) state_d = WAIT_RSP;
      WAIT_RSP: if (rsp_hit)   state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  always_comb begin
    gnt_o   = '0;
    valid_o = '0;
    rdata_o = '0;
    if (capture) gnt_o[win_idx] = 1'b1;
    if (rsp_hit) begin
      valid_o[idx_q] = 1'b1;
      rdata_o        = adp_rdata_i;
    end
  end

  assign adp_req_o   = (state_q == ISSUE);
  assign adp_burst_o = burst_q;
  assign adp_we_o    = we_q;
  assign adp_addr_o  = addr_q;
  assign adp_wdata_o = wdata_q;
  assign adp_be_o    = be_q;
  assign adp_size_o  = size_q;
  assign adp_id_o    = AXI_ID_WIDTH'(idx_q);
  assign error_o     = error_q;

endmodule

// File: tb/tb_axi_adapter_arbiter.sv
// tb/tb_axi_adapter_arbiter.sv - scoreboard bench for axi_adapter_arbiter with a transaction-level reference model
module tb_axi_adapter_arbiter;

  localparam int NP = 3;

  logic                      clk_i;
  logic                      rst_ni;
  logic [NP-1:0]             req, burst, we;
  logic [NP-1:0][63:0]       addr;
  logic [NP-1:0][255:0]      wdata;
  logic [NP-1:0][31:0]       be;
  logic [NP-1:0][1:0]        size;
  logic [NP-1:0]             gnt_o, valid_o;
  logic [255:0]              rdata_o;
  logic                      adp_req_o, adp_burst_o, adp_we_o;
  logic [63:0]               adp_addr_o;
  logic [255:0]              adp_wdata_o;
  logic [31:0]               adp_be_o;
  logic [1:0]                adp_size_o;
  logic [3:0]                adp_id_o;
  logic                      adp_gnt, adp_valid;
  logic [255:0]              adp_rdata;
  logic [3:0]                adp_id;
  logic                      error_o;

  axi_adapter_arbiter dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .req_i(req), .burst_i(burst), .we_i(we), .addr_i(addr), .wdata_i(wdata), .be_i(be), .size_i(size),
    .gnt_o(gnt_o), .valid_o(valid_o), .rdata_o(rdata_o),
    .adp_req_o(adp_req_o), .adp_burst_o(adp_burst_o), .adp_we_o(adp_we_o), .adp_addr_o(adp_addr_o),
    .adp_wdata_o(adp_wdata_o), .adp_be_o(adp_be_o), .adp_size_o(adp_size_o), .adp_id_o(adp_id_o),
    .adp_gnt_i(adp_gnt), .adp_valid_i(adp_valid), .adp_rdata_i(adp_rdata), .adp_id_i(adp_id),
    .error_o(error_o)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  typedef struct {
    int           port;
    logic         burst, we;
    logic [63:0]  addr;
    logic [255:0] wdata;
    logic [31:0]  be;
    logic [1:0]   size;
  } txn_t;

  int   n_chk = 0, n_fail = 0;
  txn_t exp_q[$];
  txn_t t;
  bit   busy = 0, issued = 0, busy0, err_exp = 0;
  int   out_port = 0, rr_last = NP - 1, w;
  logic [NP-1:0] eg, ev;

  task automatic check(input bit ok, input string nm, input logic [255:0] act, input logic [255:0] exp);
    n_chk++;
    if (!ok) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic [255:0] rnd256();
    logic [255:0] r;
    for (int i = 0; i < 8; i++) r[i*32 +: 32] = $urandom;
    return r;
  endfunction

  function automatic int exp_winner(input logic [NP-1:0] r);
`ifdef ARB_ROUND_ROBIN_EN
    for (int i = 1; i <= NP; i++) if (r[(rr_last + i) % NP]) return (rr_last + i) % NP;
`else
    for (int i = 0; i < NP; i++) if (r[i]) return i;
`endif
    return 0;
  endfunction

  // Monitor: one transaction in flight; grants push, adapter accepts pop, responses retire.
  always @(negedge clk_i) begin
    if (!rst_ni) begin
      busy = 0; issued = 0; exp_q.delete(); rr_last = NP - 1; err_exp = 0;
      check(gnt_o == '0 && valid_o == '0 && !adp_req_o && !error_o && rdata_o == '0,
            "reset_outputs", {gnt_o, valid_o, adp_req_o, error_o}, 0);
    end else begin
      busy0 = busy;
      check(error_o == err_exp, "error_flag", error_o, err_exp);
      ev = '0;
      if (adp_valid) begin
        if (issued && adp_id == 4'(out_port)) begin
          ev = NP'(1) << out_port; busy = 0; issued = 0;
        end else err_exp = 1;
      end
      check(valid_o == ev, "valid_o", valid_o, ev);
      check(rdata_o == ((ev != '0) ? adp_rdata : 256'd0), "rdata_o", rdata_o, (ev != '0) ? adp_rdata : 256'd0);
      check(adp_req_o == (exp_q.size() != 0), "adp_req", adp_req_o, exp_q.size() != 0);
      if (adp_req_o && adp_gnt && exp_q.size() != 0) begin
        t = exp_q.pop_front();
        check(adp_id_o == 4'(t.port), "adp_id", adp_id_o, t.port);
        check({adp_burst_o, adp_we_o, adp_size_o, adp_be_o, adp_addr_o} == {t.burst, t.we, t.size, t.be, t.addr},
              "adp_ctrl", {adp_burst_o, adp_we_o, adp_size_o, adp_be_o, adp_addr_o}, {t.burst, t.we, t.size, t.be, t.addr});
        check(adp_wdata_o == t.wdata, "adp_wdata", adp_wdata_o, t.wdata);
        issued = 1; out_port = t.port;
      end
      eg = '0;
      if (!busy0 && req != '0) begin
        w = exp_winner(req);
        eg = NP'(1) << w;
        t.port = w; t.burst = burst[w]; t.we = we[w]; t.addr = addr[w];
        t.wdata = wdata[w]; t.be = be[w]; t.size = size[w];
        exp_q.push_back(t); busy = 1; rr_last = w;
      end
      check(gnt_o == eg, "gnt_o", gnt_o, eg);
    end
  end

  task automatic cyc();
    @(posedge clk_i); #1;
  endtask

  task automatic rand_payload(input int p);
    burst[p] = 1'($urandom); we[p] = 1'($urandom); addr[p] = {$urandom, $urandom};
    wdata[p] = rnd256(); be[p] = $urandom; size[p] = 2'($urandom);
  endtask

  task automatic wait_any_gnt(output int p, output int n);
    p = -1; n = 0;
    @(negedge clk_i);
    while (gnt_o == '0 && n < 20) begin @(negedge clk_i); n++; end
    check(gnt_o != '0, "gnt_timeout", gnt_o, 1);
    for (int i = 0; i < NP; i++) if (gnt_o[i]) p = i;
  endtask

  task automatic finish_txn(input int p, input int stall, input logic [255:0] d, input bit drop, input bit disturb);
    cyc();
    if (drop) req[p] = 1'b0;
    if (disturb) begin req[0] = 1'b1; addr[p] = ~addr[p]; end
    for (int s = 0; s <= stall; s++) begin
      if (s == stall) adp_gnt = 1'b1;
      @(negedge clk_i);
      check(adp_req_o == 1'b1, "issue_req", adp_req_o, 1);
      check(adp_id_o == 4'(p), "issue_id", adp_id_o, p);
      check(gnt_o == '0, "issue_nognt", gnt_o, 0);
      cyc();
    end
    adp_gnt = 1'b0; adp_valid = 1'b1; adp_id = 4'(p); adp_rdata = d;
    @(negedge clk_i);
    check(valid_o == (NP'(1) << p), "rsp_valid", valid_o, NP'(1) << p);
    check(rdata_o == d, "rsp_rdata", rdata_o, d);
    cyc();
    adp_valid = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  int p, n;
  int got[4];
  int exp_seq[4];
  logic [NP-1:0] g_s;
  logic areq_s;
  logic [3:0] aid_s, owe_id;
  bit owe;
  int wcnt;
  logic [255:0] a5;

  initial begin
    rst_ni = 1'b0; req = '0; burst = '0; we = '0; addr = '0; wdata = '0; be = '0; size = '0;
    adp_gnt = 1'b0; adp_valid = 1'b0; adp_rdata = '0; adp_id = '0;
    owe = 0; owe_id = '0; wcnt = 0;
    a5 = {8{32'hA5A5_A5A5}};
    repeat (3) @(posedge clk_i);
    #1 rst_ni = 1'b1;

    // Contention from reset: all three held high
    cyc();
    for (int i = 0; i < NP; i++) rand_payload(i);
    req = '1;
    for (int k = 0; k < 4; k++) begin
      wait_any_gnt(p, n);
      got[k] = p;
      if (k > 0) check(n == 0, "b2b_gnt_latency", n, 0);
      finish_txn(p, 0, rnd256(), 0, 0);
    end
    req = '0;
`ifdef ARB_ROUND_ROBIN_EN
    exp_seq = '{0, 1, 2, 0};
`else
    exp_seq = '{0, 0, 0, 0};
`endif
    for (int k = 0; k < 4; k++) check(got[k] == exp_seq[k], "contention_order", got[k], exp_seq[k]);

    // Single burst read on port 1
    cyc();
    burst[1] = 1'b1; we[1] = 1'b0; addr[1] = 64'h8000_0040; wdata[1] = '0; be[1] = '1; size[1] = 2'd3;
    req[1] = 1'b1;
    wait_any_gnt(p, n);
    check(gnt_o == 3'b010 && n == 0, "single_gnt", {n[7:0], gnt_o}, 3'b010);
    finish_txn(1, 0, a5, 1, 0);

    // Adapter grant stall with a competing request and a changed payload
    cyc();
    rand_payload(2); req[2] = 1'b1;
    wait_any_gnt(p, n);
    check(p == 2, "stall_winner", p, 2);
    finish_txn(2, 5, rnd256(), 1, 1);
    wait_any_gnt(p, n);
    check(p == 0 && n == 0, "post_stall_winner", p, 0);
    finish_txn(0, 0, rnd256(), 1, 0);

    // Wrong response ID
    cyc();
    rand_payload(2); req[2] = 1'b1;
    wait_any_gnt(p, n);
    check(p == 2, "wrongid_winner", p, 2);
    cyc(); req[2] = 1'b0; adp_gnt = 1'b1;
    cyc(); adp_gnt = 1'b0; adp_valid = 1'b1; adp_id = 4'd0; adp_rdata = rnd256();
    @(negedge clk_i);
    check(valid_o == '0, "wrongid_novalid", valid_o, 0);
    cyc(); adp_valid = 1'b0;
    @(negedge clk_i);
    check(error_o == 1'b1, "wrongid_error", error_o, 1);
    cyc(); adp_valid = 1'b1; adp_id = 4'd2; adp_rdata = a5;
    @(negedge clk_i);
    check(valid_o == 3'b100 && rdata_o == a5, "wrongid_recover", valid_o, 3'b100);
    cyc(); adp_valid = 1'b0;
    @(negedge clk_i);
    check(error_o == 1'b1, "error_sticky", error_o, 1);

    // Reset during WAIT_RSP
    cyc();
    rand_payload(1); req[1] = 1'b1;
    wait_any_gnt(p, n);
    cyc(); req[1] = 1'b0; adp_gnt = 1'b1;
    cyc(); adp_gnt = 1'b0; rst_ni = 1'b0;
    @(negedge clk_i);
    check(!adp_req_o && valid_o == '0 && gnt_o == '0 && !error_o, "midop_reset", {adp_req_o, valid_o, gnt_o, error_o}, 0);
    cyc(); rst_ni = 1'b1; rand_payload(0); req[0] = 1'b1;
    wait_any_gnt(p, n);
    check(p == 0 && n == 0, "after_reset_gnt", p, 0);
    finish_txn(0, 1, rnd256(), 1, 0);

    // Randomized traffic with a reactive adapter model and stray responses
    for (int c = 0; c < 3000; c++) begin
      @(negedge clk_i);
      g_s = gnt_o; areq_s = adp_req_o; aid_s = adp_id_o;
      cyc();
      adp_gnt = 1'b0; adp_valid = 1'b0;
      for (int i = 0; i < NP; i++) begin
        if (g_s[i]) req[i] = 1'b0;
        else if (req[i] && $urandom_range(0, 31) == 0) req[i] = 1'b0;
        else if (!req[i] && c < 2800 && $urandom_range(0, 3) == 0) begin rand_payload(i); req[i] = 1'b1; end
      end
      if (owe) begin
        if (wcnt == 0) begin
          adp_valid = 1'b1; adp_id = owe_id; adp_rdata = rnd256(); owe = 0;
        end else begin
          wcnt--;
          if ($urandom_range(0, 7) == 0) begin
            adp_valid = 1'b1; adp_id = owe_id ^ 4'($urandom_range(1, 15)); adp_rdata = rnd256();
          end
        end
      end else if (areq_s && $urandom_range(0, 2) == 0) begin
        adp_gnt = 1'b1; owe = 1; owe_id = aid_s; wcnt = $urandom_range(0, 3);
      end else if ($urandom_range(0, 15) == 0) begin
        adp_valid = 1'b1; adp_id = 4'($urandom_range(0, 15)); adp_rdata = rnd256();
      end
    end
    cyc();
    adp_gnt = 1'b0; adp_valid = 1'b0; req = '0;
    repeat (5) cyc();
    check(!busy && exp_q.size() == 0, "drain_idle", busy, 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
